regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-port register file with a per-register busy scoreboard, for the next-generation core datapath. Provides RD_PORTS registered read ports and two write ports, with optional write-to-read bypass and an optional hardwired-zero register 0. The scoreboard tracks registers claimed by in-flight producers, so issue logic can stall on RAW hazards without its own tracking.

## Interface
- DATA_W, 16, register word width in bits
- ADDR_W, 5, index width; DEPTH = 2**ADDR_W registers
- RD_PORTS, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and claims
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = read-before-write

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- r_en  in  RD_PORTS  per-port read enable
- r_idx  in  RD_PORTS*ADDR_W  read indices, port p at [p*ADDR_W +: ADDR_W]
- r_data  out  RD_PORTS*DATA_W  registered read data, port p at [p*DATA_W +: DATA_W]
- r_valid  out  RD_PORTS  registered copy of r_en
- r_busy  out  RD_PORTS  registered busy status of the register read
- w_en_a, w_en_b  in  1 each  write enables
- w_idx_a, w_idx_b  in  ADDR_W each  write indices
- w_data_a, w_data_b  in  DATA_W each  write data
- claim_en  in  1  mark claim_idx busy (producer issued)
- claim_idx  in  ADDR_W  register to claim
- busy_count  out  ADDR_W+1  number of busy registers, registered

## Operation
- Reset (reset low) has absolute priority; no read, write or claim takes effect that edge. All registers, r_data, r_valid, r_busy, busy bits and busy_count go to 0.
- Writes:
  - Each enabled write port stores its data at the rising edge.
  - w_en_a and w_en_b to the same index: port B wins, port A is discarded.
  - Different indices: both are written.
- Scoreboard:
  - claim sets busy[claim_idx]. A write on either port clears busy[w_idx].
  - Claim and write to the same index in the same cycle: claim wins (busy = 1). The write data is still stored.
- ZERO_REG=1: writes and claims to index 0 are ignored. Register 0 reads 0 with r_busy 0.
- Read, port p with r_en[p] = 1:
  - r_data[p] takes the register value.
  - If BYPASS = 1 and a same-cycle write targets r_idx[p], r_data[p] takes the winning write data instead (B over A).
  - If BYPASS = 0, r_data[p] takes the pre-write value.
  - r_busy[p] takes the next-state busy bit of r_idx[p], i.e. after this edge's claim/write.
- Read with r_en[p] = 0: r_data[p] and r_busy[p] hold, and r_valid[p] goes to 0.
- Multiple ports may read the same index. Reads are independent of each other.
- busy_count equals the population count of the busy bits after each edge. Range 0..DEPTH, or 0..DEPTH-1 when ZERO_REG = 1.

## Timing
- Read latency 1 cycle: index and enable sampled at edge N, data valid after edge N with r_valid high.
- Write latency 1 cycle. With BYPASS = 0, a read issued at the write edge sees the old value; a read at edge N+1 sees the new value.
- Claim is visible on r_busy for reads sampled at the same edge; busy_count updates at the same edge.
- No handshake back-pressure: all ports accept every cycle.
- Reset assertion mid-operation clears state asynchronously. The first edge after deassertion operates normally.

## Test plan
- Reset, write 0x1234 to r5 via port A, read r5 on both ports next cycle -> r_data 0x1234 on both, r_valid 1, r_busy 0.
- Same cycle: A writes 0xAAAA to r7, B writes 0x5555 to r7, port 0 reads r7 -> BYPASS=1: 0x5555 same cycle; read next cycle: 0x5555. BYPASS=0: same-cycle read returns 0x0000.
- Claim r3 -> busy_count 1, read r3 gives r_busy 1. Write r3 = 0x00FF -> busy_count 0. Claim and write r3 together -> busy_count 1, data 0x00FF stored.
- ZERO_REG=1: write 0xFFFF to r0 and claim r0 -> read r0 gives 0x0000, r_busy 0, busy_count unchanged.
- Claim r1..r31 on successive cycles -> busy_count 31. Assert reset mid-sequence -> all outputs 0 immediately; a subsequent read of r1 returns 0x0000.
- Read r9 with r_en high, then hold r_en low for 3 cycles while writing r9 = 0xBEEF -> r_data holds the old value, r_valid 0.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port register file: read ports, two write
// ports, the scoreboard claim port and the busy count.
interface regfile_mp_if #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 5,
  parameter int RD_PORTS = 2
) ();

  logic [RD_PORTS-1:0]        r_en;
  logic [RD_PORTS*ADDR_W-1:0] r_idx;
  logic [RD_PORTS*DATA_W-1:0] r_data;
  logic [RD_PORTS-1:0]        r_valid;
  logic [RD_PORTS-1:0]        r_busy;

  logic                       w_en_a;
  logic [ADDR_W-1:0]          w_idx_a;
  logic [DATA_W-1:0]          w_data_a;
  logic                       w_en_b;
  logic [ADDR_W-1:0]          w_idx_b;
  logic [DATA_W-1:0]          w_data_b;

  logic                       claim_en;
  logic [ADDR_W-1:0]          claim_idx;
  logic [ADDR_W:0]            busy_count;

  // Issue/writeback side drives requests and observes results
  modport master (
    output r_en, r_idx, w_en_a, w_idx_a, w_data_a, w_en_b, w_idx_b, w_data_b,
           claim_en, claim_idx,
    input  r_data, r_valid, r_busy, busy_count
  );

  // Register file side
  modport slave (
    input  r_en, r_idx, w_en_a, w_idx_a, w_data_a, w_en_b, w_idx_b, w_data_b,
           claim_en, claim_idx,
    output r_data, r_valid, r_busy, busy_count
  );

endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with two write ports, registered read ports,
// optional write-to-read bypass, optional hardwired-zero register 0 and a
// per-register busy scoreboard with a registered population count.
module regfile_mp #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 5,
  parameter int RD_PORTS = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic          clk,
  input  logic          reset,
  regfile_mp_if.slave   bus
);

  localparam int DEPTH = 1 << ADDR_W;

  // Architectural state
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [ADDR_W:0]   busy_count_q;
  logic [ADDR_W:0]   busy_count_d;

  // Read-port output registers
  logic [DATA_W-1:0] r_data_q  [RD_PORTS];
  logic              r_valid_q [RD_PORTS];
  logic              r_busy_q  [RD_PORTS];

  // Qualified write/claim requests
  logic wr_a_ok;
  logic wr_b_ok;
  logic claim_ok;

  // Qualify requests: index 0 is inert when hardwired to zero, and port A
  // is dropped when port B targets the same register.
  always_comb begin
    wr_b_ok  = bus.w_en_b;
    wr_a_ok  = bus.w_en_a && !(bus.w_en_b && (bus.w_idx_b == bus.w_idx_a));
    claim_ok = bus.claim_en;
    if (ZERO_REG != 0) begin
      if (bus.w_idx_b == '0)   wr_b_ok  = 1'b0;
      if (bus.w_idx_a == '0)   wr_a_ok  = 1'b0;
      if (bus.claim_idx == '0) claim_ok = 1'b0;
    end
  end

  // Per-entry next state: B over A for data, claim over write for busy
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic hit_a;
    logic hit_b;
    logic hit_claim;

    assign hit_a     = wr_a_ok  && (bus.w_idx_a   == ADDR_W'(gi));
    assign hit_b     = wr_b_ok  && (bus.w_idx_b   == ADDR_W'(gi));
    assign hit_claim = claim_ok && (bus.claim_idx == ADDR_W'(gi));

    // Next-state data and busy bit for this register
    always_comb begin
      regs_d[gi] = regs_q[gi];
      busy_d[gi] = busy_q[gi];
      if (hit_b) begin
        regs_d[gi] = bus.w_data_b;
      end else if (hit_a) begin
        regs_d[gi] = bus.w_data_a;
      end
      if (hit_a || hit_b) begin
        busy_d[gi] = 1'b0;
      end
      if (hit_claim) begin
        busy_d[gi] = 1'b1;
      end
    end
  end

  // Population count of the next-state busy bits
  always_comb begin
    busy_count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_count_d = busy_count_d + (ADDR_W + 1)'(busy_d[i]);
    end
  end

  // Register array, scoreboard and busy count update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  // Read ports
  for (genvar gi = 0; gi < RD_PORTS; gi++) begin : g_rd
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data_d;
    logic              busy_bit_d;

    assign idx = bus.r_idx[gi*ADDR_W +: ADDR_W];

    // Select stored value, or the winning same-cycle write when bypassing
    always_comb begin
      data_d     = regs_q[idx];
      busy_bit_d = busy_d[idx];
      if (BYPASS != 0) begin
        if (wr_b_ok && (bus.w_idx_b == idx)) begin
          data_d = bus.w_data_b;
        end else if (wr_a_ok && (bus.w_idx_a == idx)) begin
          data_d = bus.w_data_a;
        end
      end
      if ((ZERO_REG != 0) && (idx == '0)) begin
        data_d     = '0;
        busy_bit_d = 1'b0;
      end
    end

    // Capture on enable; hold data/busy otherwise, valid follows enable
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_data_q[gi]  <= '0;
        r_busy_q[gi]  <= 1'b0;
        r_valid_q[gi] <= 1'b0;
      end else begin
        r_valid_q[gi] <= bus.r_en[gi];
        if (bus.r_en[gi]) begin
          r_data_q[gi] <= data_d;
          r_busy_q[gi] <= busy_bit_d;
        end
      end
    end
  end

  // Pack per-port registers onto the bus
  always_comb begin
    bus.r_data  = '0;
    bus.r_valid = '0;
    bus.r_busy  = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      bus.r_data[p*DATA_W +: DATA_W] = r_data_q[p];
      bus.r_valid[p]                 = r_valid_q[p];
      bus.r_busy[p]                  = r_busy_q[p];
    end
  end

  assign bus.busy_count = busy_count_q;

endmodule
